// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Reset-time configuration reproduces the legacy fixed 1101 overlapping detector.
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;
  localparam int         DEFAULT_LEN     = 4;
  localparam int         MIN_LEN         = 1;

  // Lengths outside 1..max_len are stored as the nearest legal length.
  function automatic int clamp_len(input int len, input int max_len);
    if (len < MIN_LEN) return MIN_LEN;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage : seq_det_pkg

// File: rtl/seq_det_shifter.sv
// Bit history, saturating fill counter and length-masked pattern compare.
module seq_det_shifter #(
  parameter  int MAX_LEN = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_en,
  input  logic               clear,
  input  logic               clear_fill,
  input  logic               din,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] history_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_next;

  // hit looks at the value the history will hold after this edge, so the
  // controller can register the match pulse on the same edge as the shift.
  always_comb begin
    history_next = {history[MAX_LEN-2:0], din};
    fill_next    = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    // len == MAX_LEN wraps the shift to zero, giving an all-ones mask.
    mask         = (MAX_LEN'(1) << len) - MAX_LEN'(1);
    hit          = shift_en && (fill_next >= len) &&
                   ((history_next & mask) == (pattern & mask));
  end

  // NOTE: non-blocking assignments let every flop in this block sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      history <= '0;
      fill    <= '0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
    end else if (shift_en) begin
      history <= history_next;
      fill    <= clear_fill ? '0 : fill_next;
    end
  end

endmodule : seq_det_shifter

// File: rtl/seq_det_ctrl.sv
// Detector controller: configuration handshake, arm/disarm FSM and match counting.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_match_limit,
  input  logic               start,
  input  logic               abort,
  input  logic               din,
  input  logic               din_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done
);

  state_t             state;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [CNT_W-1:0]   limit_q;

  logic               cfg_fire;
  logic               start_go;
  logic               shift_en;
  logic               clear_fill;
  logic               hit;
  logic               limit_hit;
  logic [CNT_W-1:0]   count_inc;

  assign cfg_ready = !busy;
  assign cfg_fire  = cfg_valid && cfg_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    start_go = 1'b0;
    shift_en = 1'b0;
    case (state)
      IDLE:    start_go = start;
      ARMED:   shift_en = din_valid && !abort;
      DONE:    start_go = start && !abort;
      default: start_go = 1'b0;
    endcase
    clear_fill = hit && !overlap_q;
    count_inc  = (match_count == '1) ? match_count : match_count + CNT_W'(1);
    limit_hit  = (limit_q != '0) && (count_inc == limit_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= MAX_LEN'(DEFAULT_PATTERN);
      len_q     <= LEN_W'(DEFAULT_LEN);
      overlap_q <= 1'b1;
      limit_q   <= '0;
    end else if (cfg_fire) begin
      pattern_q <= cfg_pattern;
      len_q     <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
      overlap_q <= cfg_overlap;
      limit_q   <= cfg_match_limit;
    end
  end

  seq_det_shifter #(
    .MAX_LEN (MAX_LEN)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .shift_en   (shift_en),
    .clear      (start_go),
    .clear_fill (clear_fill),
    .din        (din),
    .pattern    (pattern_q),
    .len        (len_q),
    .hit        (hit)
  );

  // Abort is tested before the hit so a coincident match is dropped entirely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      match       <= 1'b0;
      match_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      match <= 1'b0;
      case (state)
        IDLE: begin
          if (start_go) begin
            state       <= ARMED;
            busy        <= 1'b1;
            match_count <= '0;
          end
        end
        ARMED: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (hit) begin
            match       <= 1'b1;
            match_count <= count_inc;
            if (limit_hit) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (abort) begin
            state <= IDLE;
            done  <= 1'b0;
          end else if (start_go) begin
            state       <= ARMED;
            busy        <= 1'b1;
            done        <= 1'b0;
            match_count <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule : seq_det_ctrl

// File: tb/tb_seq_det_ctrl.sv
// Directed scenario bench for seq_det_ctrl with hand-computed expectations.
module tb_seq_det_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_match_limit;
  logic               start;
  logic               abort;
  logic               din;
  logic               din_valid;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_det_ctrl #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_pattern     (cfg_pattern),
    .cfg_len         (cfg_len),
    .cfg_overlap     (cfg_overlap),
    .cfg_match_limit (cfg_match_limit),
    .start           (start),
    .abort           (abort),
    .din             (din),
    .din_valid       (din_valid),
    .match           (match),
    .match_count     (match_count),
    .busy            (busy),
    .done            (done)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din       = b;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic ov,
                        input logic [7:0] lim);
    cfg_pattern     = p;
    cfg_len         = l;
    cfg_overlap     = ov;
    cfg_match_limit = lim;
    cfg_valid       = 1'b1;
    step();
    cfg_valid       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_match_limit = '0; start = 1'b0; abort = 1'b0; din = 1'b0; din_valid = 1'b0;
    repeat (2) step();
    checks++;
    if ({match, busy, done, cfg_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_flags: match/busy/done/ready=%b expected 0001",
               {match, busy, done, cfg_ready});
    end
    checks++;
    if (match_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_count: got %0d expected 0", match_count);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_default_overlap();
    logic [6:0] bits;
    logic [6:0] exp;
    bits = 7'b1101101;
    exp  = 7'b0001001;
    do_start();
    for (int i = 0; i < 7; i++) begin
      send_bit(bits[6-i]);
      checks++;
      if (match !== exp[6-i]) begin
        failures++;
        $display("FAIL default_overlap_match bit%0d: got %b expected %b", i + 1, match, exp[6-i]);
      end
    end
    checks++;
    if (match_count !== 8'd2 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL default_overlap_end: count=%0d busy=%b done=%b expected 2 1 0",
               match_count, busy, done);
    end
  endtask

  task automatic test_no_overlap();
    logic [6:0] bits;
    logic [6:0] exp;
    bits = 7'b1101101;
    exp  = 7'b0001000;
    do_abort();
    do_cfg(8'h0D, 4'd4, 1'b0, 8'd0);
    do_start();
    for (int i = 0; i < 7; i++) begin
      send_bit(bits[6-i]);
      checks++;
      if (match !== exp[6-i]) begin
        failures++;
        $display("FAIL no_overlap_match bit%0d: got %b expected %b", i + 1, match, exp[6-i]);
      end
    end
    checks++;
    if (match_count !== 8'd1) begin
      failures++;
      $display("FAIL no_overlap_count: got %0d expected 1", match_count);
    end
  endtask

  task automatic test_limit();
    logic [7:0] bits;
    logic [7:0] exp;
    bits = 8'b11011101;
    exp  = 8'b00010001;
    do_abort();
    do_cfg(8'h0D, 4'd4, 1'b1, 8'd2);
    do_start();
    for (int i = 0; i < 8; i++) begin
      send_bit(bits[7-i]);
      checks++;
      if (match !== exp[7-i] || done !== (i == 7)) begin
        failures++;
        $display("FAIL limit_match bit%0d: match=%b done=%b expected %b %b",
                 i + 1, match, done, exp[7-i], (i == 7));
      end
    end
    checks++;
    if (match_count !== 8'd2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL limit_done_state: count=%0d busy=%b expected 2 0", match_count, busy);
    end
    for (int i = 0; i < 4; i++) begin
      send_bit(bits[7-i]);
      checks++;
      if (match !== 1'b0 || match_count !== 8'd2) begin
        failures++;
        $display("FAIL limit_ignored bit%0d: match=%b count=%0d expected 0 2",
                 i + 1, match, match_count);
      end
    end
    do_start();
    checks++;
    if (match_count !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL limit_restart: count=%0d busy=%b done=%b expected 0 1 0",
               match_count, busy, done);
    end
  endtask

  task automatic test_gaps_and_abort();
    logic [3:0] bits;
    bits = 4'b1101;
    do_abort();
    do_cfg(8'h0D, 4'd4, 1'b1, 8'd0);
    do_start();
    for (int i = 0; i < 4; i++) begin
      send_bit(bits[3-i]);
      checks++;
      if (match !== (i == 3)) begin
        failures++;
        $display("FAIL gap_match bit%0d: got %b expected %b", i + 1, match, (i == 3));
      end
      for (int g = 0; g < 3; g++) begin
        din       = ~bits[3-i];
        din_valid = 1'b0;
        step();
        checks++;
        if (match !== 1'b0) begin
          failures++;
          $display("FAIL gap_idle bit%0d gap%0d: got %b expected 0", i + 1, g, match);
        end
      end
    end
    checks++;
    if (match_count !== 8'd1) begin
      failures++;
      $display("FAIL gap_count: got %0d expected 1", match_count);
    end
    do_abort();
    do_start();
    for (int i = 0; i < 3; i++) send_bit(bits[3-i]);
    din = 1'b1; din_valid = 1'b1; abort = 1'b1;
    step();
    din_valid = 1'b0; abort = 1'b0;
    checks++;
    if (match !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_suppress: match=%b busy=%b done=%b ready=%b expected 0 0 0 1",
               match, busy, done, cfg_ready);
    end
    checks++;
    if (match_count !== 8'd0) begin
      failures++;
      $display("FAIL abort_count: got %0d expected 0", match_count);
    end
  endtask

  task automatic test_len_clamp_and_cfg_block();
    logic [2:0] bits3;
    logic [7:0] pat;
    bits3 = 3'b101;
    pat   = 8'hD0;
    do_cfg(8'h01, 4'd0, 1'b1, 8'd0);
    do_start();
    for (int i = 0; i < 3; i++) begin
      send_bit(bits3[2-i]);
      checks++;
      if (match !== bits3[2-i]) begin
        failures++;
        $display("FAIL len0_match bit%0d: got %b expected %b", i + 1, match, bits3[2-i]);
      end
    end
    checks++;
    if (match_count !== 8'd2) begin
      failures++;
      $display("FAIL len0_count: got %0d expected 2", match_count);
    end
    do_abort();
    do_cfg(pat, 4'd15, 1'b1, 8'd0);
    do_start();
    for (int i = 0; i < 8; i++) begin
      send_bit(pat[7-i]);
      checks++;
      if (match !== (i == 7)) begin
        failures++;
        $display("FAIL len15_match bit%0d: got %b expected %b", i + 1, match, (i == 7));
      end
    end
    cfg_pattern = 8'h00; cfg_len = 4'd1; cfg_overlap = 1'b1; cfg_match_limit = 8'd1;
    cfg_valid   = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL armed_ready: got %b expected 0", cfg_ready);
    end
    for (int i = 0; i < 8; i++) begin
      send_bit(pat[7-i]);
      checks++;
      if (match !== (i == 7)) begin
        failures++;
        $display("FAIL armed_cfg_ignored bit%0d: got %b expected %b", i + 1, match, (i == 7));
      end
    end
    cfg_valid = 1'b0;
    checks++;
    if (match_count !== 8'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL armed_cfg_count: count=%0d busy=%b expected 2 1", match_count, busy);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] bits;
    bits = 4'b0110;
    do_abort();
    do_cfg(8'h06, 4'd4, 1'b1, 8'd0);
    do_start();
    for (int i = 0; i < 4; i++) send_bit(bits[3-i]);
    checks++;
    if (match !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_match: got %b expected 1", match);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({match, busy, done, cfg_ready} !== 4'b0001 || match_count !== 8'd0) begin
      failures++;
      $display("FAIL async_reset: match/busy/done/ready=%b count=%0d expected 0001 0",
               {match, busy, done, cfg_ready}, match_count);
    end
    #2 reset = 1'b0;
    do_start();
    send_bit(1'b1);
    checks++;
    if (match !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_first: got %b expected 0", match);
    end
    bits = 4'b1101;
    for (int i = 1; i < 4; i++) begin
      send_bit(bits[3-i]);
      checks++;
      if (match !== (i == 3)) begin
        failures++;
        $display("FAIL post_reset_default bit%0d: got %b expected %b", i + 1, match, (i == 3));
      end
    end
    checks++;
    if (match_count !== 8'd1) begin
      failures++;
      $display("FAIL post_reset_count: got %0d expected 1", match_count);
    end
  endtask

  initial begin
    test_reset();
    test_default_overlap();
    test_no_overlap();
    test_limit();
    test_gaps_and_abort();
    test_len_clamp_and_cfg_block();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_seq_det_ctrl

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable serial pattern-detector controller. It owns the detector configuration (pattern, length, overlap mode, match limit), takes that configuration through a ready/valid handshake, and arms and disarms detection. It counts matches and signals completion. It sits between the control/register side and the serial bit stream, generalising the team's fixed 1101 overlapping detector into a schedulable resource.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (must be >= 4)
CNT_W, 8, width of match counter and match limit
LEN_W, $clog2(MAX_LEN+1), width of the length field (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-high reset
cfg_valid  input  1  configuration offer
cfg_ready  output  1  configuration accepted when high with cfg_valid (= !busy)
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is first bit received, bit [0] is last
cfg_len  input  LEN_W  pattern length
cfg_overlap  input  1  1 = overlapping matches allowed
cfg_match_limit  input  CNT_W  matches before DONE; 0 = unlimited
start  input  1  arm detection
abort  input  1  disarm detection
din  input  1  serial data bit
din_valid  input  1  din qualifier
match  output  1  one-cycle pulse per detected pattern
match_count  output  CNT_W  matches since last start, saturating
busy  output  1  high in ARMED
done  output  1  high in DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset values: state IDLE; match, match_count, busy and done are 0; cfg_ready is 1; shift history and fill counter are 0.
- Reset configuration: pattern 'b1101 (LSB-aligned), len 4, overlap 1, limit 0.
- States:
  - IDLE: start goes to ARMED.
  - ARMED: abort goes to IDLE. Reaching the match limit goes to DONE.
  - DONE: start goes to ARMED. abort goes to IDLE.
- Config handshake: a transfer occurs at a posedge with cfg_valid && cfg_ready. The config registers update at that edge.
- Config handshake, ARMED: cfg_ready is 0 and offers are ignored.
- Config handshake, start on the same edge in IDLE/DONE: the newly latched config governs the run.
- Length clamp: cfg_len = 0 is stored as 1. cfg_len > MAX_LEN is stored as MAX_LEN.
- start (IDLE/DONE): clears history, fill counter and match_count; done drops.
- Shifting in ARMED: each clk edge with din_valid shifts din into the history LSB (older bits move toward the MSB). The fill counter increments, saturating at MAX_LEN.
- din_valid = 0: history and fill counter hold.
- Match condition: fill >= len and history[len-1:0] == pattern[len-1:0], both evaluated on the post-shift value.
- Match timing: match is registered and high for exactly the one cycle after the edge that sampled the completing bit. match_count increments on that same edge, saturating at all-ones.
- Overlap = 1: history is retained after a match, so 1101101 produces two matches.
- Overlap = 0: after a match the fill counter is cleared, so the next match needs len fresh bits.
- Limit: if limit != 0 and the incremented count == limit, the state goes to DONE on the same edge. The match pulse still fires. din is ignored in DONE.
- abort in ARMED: goes to IDLE next edge. Any coincident match is suppressed (no pulse, no increment). match_count holds for readout.
- abort priority: abort has priority over the limit→DONE transition.
- abort outside ARMED: in IDLE it is ignored; in DONE it goes to IDLE.
- start in ARMED: ignored.
- Async reset mid-run: returns immediately to the reset state and reset config. Any pending match pulse is dropped.

Decomposition:
- Package seq_det_pkg:
  - state enum (IDLE, ARMED, DONE)
  - DEFAULT_PATTERN = 'b1101, DEFAULT_LEN = 4
  - length-clamp function
- One sub-module, seq_det_shifter:
  - history shift register, saturating fill counter, masked compare
  - inputs: shift_en, clear, clear_fill
  - output: hit (combinational on post-shift value)
- seq_det_ctrl holds the FSM, config registers, handshake and counter.

Test Plan:
1. Reset-default config, start, din_valid=1 on every bit, stream 1,1,0,1,1,0,1 → match pulses after bits 4 and 7; match_count = 2; busy = 1; done = 0.
2. Config pattern 'b1101, len 4, overlap 0, same stream → a single match after bit 4; match_count = 1.
3. Config limit 2, overlap 1, stream 1,1,0,1,1,1,0,1 → matches after bits 4 and 8; done = 1 on the same edge as the second match; later bits are ignored; start clears the count to 0 and re-arms.
4. Stream 1101 with din_valid low for 3 cycles between each bit → exactly one match, aligned to the last valid bit. Stream 1,1,0 then abort coincident with the final 1 → no match, state IDLE, count 0.
5. cfg_len = 0, pattern bit0 = 1, stream 1,0,1 → matches after bits 1 and 3. cfg_len = 15 with MAX_LEN = 8 → stored len = 8. cfg_valid while ARMED → cfg_ready = 0 and config unchanged.
6. Assert reset asynchronously mid-run after 1,1,0 → outputs are 0 immediately and config returns to 1101/4. Start, then stream 1 → no match (fill was cleared).
